// File: rtl/pose_sequencer.sv
// pose_sequencer: steps a VGA adapter through a four-pose animation read
// from an image ROM, then draws a full-screen end image on request.
// Each raster issues one ROM address per cycle. The pixel coordinates and
// the plot strobe travel through a ROM_LAT-deep pipeline, so every plot
// lines up with its ROM data.
// Optional feature: define POSE_SEQ_FAST_ADV_EN so that start during a
// dwell ends that dwell early.
// Request inputs: start and stop_req are level-sampled on each rising edge.
// There is no handshake back to the requester.
module pose_sequencer #(
  parameter int X_MAX   = 320,
  parameter int Y_TOP   = 75,
  parameter int Y_BOT   = 240,
  parameter int DWELL   = 100000000,
  parameter int ROM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop_req,
  output logic [1:0]  img_sel,
  output logic [16:0] rom_addr,
  output logic [8:0]  x,
  output logic [7:0]  y,
  output logic        plot,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_DRAW, S_FLUSH, S_DWELL, S_END_DRAW, S_END_FLUSH, S_END_HOLD
  } state_t;

  localparam logic [8:0] CX_LAST  = 9'(X_MAX - 1);
  localparam logic [7:0] CY_LAST  = 8'(Y_BOT - 1);
  localparam logic [7:0] CY_FIRST = 8'(Y_TOP);
  localparam logic [1:0] FL_LAST  = 2'(ROM_LAT - 1);
  localparam int         DCW      = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DCW-1:0] DW_LAST = DCW'(DWELL - 1);

  state_t          state_q;
  logic [1:0]      pose_idx_q;
  logic            stop_q;
  logic [8:0]      cx_q;
  logic [7:0]      cy_q;
  logic [16:0]     rom_addr_q;
  logic [1:0]      img_sel_q;
  logic [DCW-1:0]  dwell_cnt_q;
  logic [1:0]      flush_cnt_q;
  logic            frame_done_q;
  logic            busy_q;

  logic            pipe_v_q [ROM_LAT];
  logic [8:0]      pipe_x_q [ROM_LAT];
  logic [7:0]      pipe_y_q [ROM_LAT];

  logic            issue;
  logic            raster_last;
  logic            dwell_done;

  // Pose index to ROM mux select; the centre image is shown twice per cycle.
  function automatic logic [1:0] pose_sel(input logic [1:0] idx);
    case (idx)
      2'd0:    pose_sel = 2'b01;
      2'd1:    pose_sel = 2'b10;
      2'd2:    pose_sel = 2'b01;
      default: pose_sel = 2'b11;
    endcase
  endfunction

  assign issue       = (state_q == S_DRAW) || (state_q == S_END_DRAW);
  assign raster_last = (cx_q == CX_LAST) && (cy_q == CY_LAST);

`ifdef POSE_SEQ_FAST_ADV_EN
  assign dwell_done = (dwell_cnt_q == DW_LAST) || start;
`else
  assign dwell_done = (dwell_cnt_q == DW_LAST);
`endif

  // Main sequencer: state, raster counters, pose selection and stop flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      pose_idx_q   <= 2'd0;
      stop_q       <= 1'b0;
      cx_q         <= 9'd0;
      cy_q         <= CY_FIRST;
      rom_addr_q   <= 17'd0;
      img_sel_q    <= 2'b01;
      dwell_cnt_q  <= '0;
      flush_cnt_q  <= 2'd0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (stop_req) stop_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          // A stop request outranks a simultaneous start.
          if (stop_req) begin
            state_q    <= S_END_DRAW;
            cx_q       <= 9'd0;
            cy_q       <= 8'd0;
            rom_addr_q <= 17'd0;
            img_sel_q  <= 2'b00;
            busy_q     <= 1'b1;
          end else if (start) begin
            state_q    <= S_DRAW;
            pose_idx_q <= 2'd0;
            cx_q       <= 9'd0;
            cy_q       <= CY_FIRST;
            rom_addr_q <= 17'd0;
            img_sel_q  <= pose_sel(2'd0);
            busy_q     <= 1'b1;
          end
        end
        S_DRAW, S_END_DRAW: begin
          // The address is held on the last pixel so it never runs past the image.
          if (raster_last) begin
            state_q     <= (state_q == S_DRAW) ? S_FLUSH : S_END_FLUSH;
            flush_cnt_q <= 2'd0;
          end else begin
            rom_addr_q <= rom_addr_q + 17'd1;
            if (cx_q == CX_LAST) begin
              cx_q <= 9'd0;
              cy_q <= cy_q + 8'd1;
            end else begin
              cx_q <= cx_q + 9'd1;
            end
          end
        end
        S_FLUSH, S_END_FLUSH: begin
          // Wait for the last pixel to leave the pipeline, then flag the frame.
          if (flush_cnt_q == FL_LAST) begin
            state_q      <= (state_q == S_FLUSH) ? S_DWELL : S_END_HOLD;
            dwell_cnt_q  <= '0;
            frame_done_q <= 1'b1;
          end else begin
            flush_cnt_q <= flush_cnt_q + 2'd1;
          end
        end
        S_DWELL: begin
          if (dwell_done) begin
            dwell_cnt_q <= '0;
            cx_q        <= 9'd0;
            rom_addr_q  <= 17'd0;
            if (stop_q) begin
              state_q   <= S_END_DRAW;
              cy_q      <= 8'd0;
              img_sel_q <= 2'b00;
            end else begin
              state_q    <= S_DRAW;
              cy_q       <= CY_FIRST;
              pose_idx_q <= pose_idx_q + 2'd1;
              img_sel_q  <= pose_sel(pose_idx_q + 2'd1);
            end
          end else begin
            dwell_cnt_q <= dwell_cnt_q + 1'b1;
          end
        end
        S_END_HOLD: begin
          state_q <= S_END_HOLD;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Coordinate/strobe delay line matching the ROM read latency.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        pipe_v_q[i] <= 1'b0;
        pipe_x_q[i] <= 9'd0;
        pipe_y_q[i] <= CY_FIRST;
      end
    end else begin
      pipe_v_q[0] <= issue;
      pipe_x_q[0] <= cx_q;
      pipe_y_q[0] <= cy_q;
      for (int i = 1; i < ROM_LAT; i++) begin
        pipe_v_q[i] <= pipe_v_q[i-1];
        pipe_x_q[i] <= pipe_x_q[i-1];
        pipe_y_q[i] <= pipe_y_q[i-1];
      end
    end
  end

  assign img_sel    = img_sel_q;
  assign rom_addr   = rom_addr_q;
  assign x          = pipe_x_q[ROM_LAT-1];
  assign y          = pipe_y_q[ROM_LAT-1];
  assign plot       = pipe_v_q[ROM_LAT-1];
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
